// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters.
module alu_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int OPW = 4,
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*OPW-1:0]   req_op,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [OPW-1:0]        alu_sel,
   input  logic [WIDTH-1:0]      alu_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  busy
);
   localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
   logic [1:0] state_q, state_d;
   logic [IDW-1:0] rr_q, rr_d, id_q, id_d, g;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
   logic [OPW-1:0] sel_q, sel_d;
   logic vld_q, vld_d, any_v;

   function automatic logic [IDW-1:0] wrap(input logic [IDW-1:0] base, input int k);
      int j;
      j = int'(base) + k;
      return IDW'(j >= NREQ ? j - NREQ : j);
   endfunction

   // first valid requester at or after rr_q, cyclically
   always_comb begin
      g = '0;
      any_v = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any_v && req_valid[wrap(rr_q, k)]) begin
            g = wrap(rr_q, k);
            any_v = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d = rr_q;
      id_d = id_q;
      a_d = a_q;
      b_d = b_q;
      sel_d = sel_q;
      data_d = data_q;
      vld_d = vld_q;
      if (state_q == IDLE && any_v) begin
         a_d = req_a[g*WIDTH +: WIDTH];
         b_d = req_b[g*WIDTH +: WIDTH];
         sel_d = req_op[g*OPW +: OPW];
         id_d = g;
         rr_d = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
         state_d = EXEC;
      end
      if (state_q == EXEC) begin
         data_d = alu_result;
         vld_d = 1'b1;
         state_d = RESP;
      end
      if (state_q == RESP && rsp_ready) begin
         vld_d = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q <= '0;
         id_q <= '0;
         a_q <= '0;
         b_q <= '0;
         sel_q <= '0;
         data_q <= '0;
         vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q <= rr_d;
         id_q <= id_d;
         a_q <= a_d;
         b_q <= b_d;
         sel_q <= sel_d;
         data_q <= data_d;
         vld_q <= vld_d;
      end
   end

   assign req_ready = (state_q == IDLE && any_v && !rst) ? NREQ'(1) << g : '0;
   assign alu_a = a_q;
   assign alu_b = b_q;
   assign alu_sel = sel_q;
   assign rsp_valid = vld_q;
   assign rsp_id = id_q;
   assign rsp_data = data_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of the arbiter with an adder standing in for the ALU.
module tb_alu_share_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] rv, rrdy4;
   logic [31:0] ra, rb;
   logic [15:0] rop;
   logic [7:0] aa, ab, ares, rdata;
   logic [3:0] asel;
   logic rvld, rrdy, bsy;
   logic [1:0] rid;

   logic [2:0] v3, rrdy3;
   logic [23:0] a3, b3;
   logic [11:0] op3;
   logic [7:0] aa3, ab3, ares3, rdata3;
   logic [3:0] asel3;
   logic rvld3, bsy3;
   logic [1:0] rid3;

   int checks = 0, errors = 0;

   assign ares = aa + ab;
   assign ares3 = aa3 + ab3;

   alu_share_arbiter #(.WIDTH(8), .OPW(4), .NREQ(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rrdy4), .req_a(ra), .req_b(rb),
      .req_op(rop), .alu_a(aa), .alu_b(ab), .alu_sel(asel), .alu_result(ares),
      .rsp_valid(rvld), .rsp_ready(rrdy), .rsp_id(rid), .rsp_data(rdata), .busy(bsy));

   alu_share_arbiter #(.WIDTH(8), .OPW(4), .NREQ(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rrdy3), .req_a(a3), .req_b(b3),
      .req_op(op3), .alu_a(aa3), .alu_b(ab3), .alu_sel(asel3), .alu_result(ares3),
      .rsp_valid(rvld3), .rsp_ready(1'b1), .rsp_id(rid3), .rsp_data(rdata3), .busy(bsy3));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rv = '0; ra = '0; rb = '0; rop = '0; rrdy = 1'b1;
      v3 = '0; a3 = '0; b3 = '0; op3 = '0;
      step();
      step();
      chk("rst_valid", 32'(rvld), 0);
      chk("rst_busy", 32'(bsy), 0);
      chk("rst_alu_a", 32'(aa), 0);
      chk("rst_id", 32'(rid), 0);
      chk("rst_data", 32'(rdata), 0);
      chk("rst_ready", 32'(rrdy4), 0);
      rst = 1'b0;
      // single request from requester 1
      rv = 4'b0010; ra[15:8] = 8'd16; rb[15:8] = 8'd15; rop[7:4] = 4'b0001;
      #1 chk("single_ready", 32'(rrdy4), 32'b0010);
      step();
      rv = '0;
      chk("single_busy1", 32'(bsy), 1);
      chk("single_alu_a", 32'(aa), 16);
      chk("single_sel", 32'(asel), 1);
      chk("single_exec_valid", 32'(rvld), 0);
      step();
      chk("single_valid", 32'(rvld), 1);
      chk("single_id", 32'(rid), 1);
      chk("single_data", 32'(rdata), 8'h1F);
      chk("single_busy2", 32'(bsy), 1);
      step();
      chk("single_done", 32'(rvld), 0);
      chk("single_idle", 32'(bsy), 0);
      // rotation: grant 2, then 0 and 3 valid -> 3 first
      rv = 4'b0100; ra[23:16] = 8'd5; rb[23:16] = 8'd6;
      #1 chk("rot_ready2", 32'(rrdy4), 32'b0100);
      step(); rv = '0;
      step();
      chk("rot_id2", 32'(rid), 2);
      chk("rot_data2", 32'(rdata), 11);
      step();
      rv = 4'b1001; ra[7:0] = 8'd1; rb[7:0] = 8'd2; ra[31:24] = 8'd7; rb[31:24] = 8'd8;
      #1 chk("rot_ready3", 32'(rrdy4), 32'b1000);
      step(); rv = 4'b0001;
      #1 chk("rot_exec_noready", 32'(rrdy4), 0);
      step();
      chk("rot_id3", 32'(rid), 3);
      chk("rot_data3", 32'(rdata), 15);
      step();
      chk("rot_ready0", 32'(rrdy4), 32'b0001);
      step(); rv = '0;
      step();
      chk("rot_id0", 32'(rid), 0);
      chk("rot_data0", 32'(rdata), 3);
      step();
      // backpressure with wrapping sum
      rrdy = 1'b0;
      rv = 4'b0110; ra[15:8] = 8'd200; rb[15:8] = 8'd100; ra[23:16] = 8'd1; rb[23:16] = 8'd1;
      #1 chk("bp_ready1", 32'(rrdy4), 32'b0010);
      step(); rv = 4'b0100;
      step();
      chk("bp_valid", 32'(rvld), 1);
      chk("bp_id", 32'(rid), 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_data", 32'(rdata), 8'h2C);
         chk("bp_hold_valid", 32'(rvld), 1);
         chk("bp_hold_noready", 32'(rrdy4), 0);
         step();
      end
      rrdy = 1'b1;
      step();
      chk("bp_released", 32'(rvld), 0);
      chk("bp_next_grant", 32'(rrdy4), 32'b0100);
      step(); rv = '0;
      step();
      chk("bp_id2", 32'(rid), 2);
      chk("bp_data2", 32'(rdata), 2);
      step();
      // reset during EXEC discards the op
      rv = 4'b0001; ra[7:0] = 8'd9; rb[7:0] = 8'd9;
      step();
      chk("mid_busy", 32'(bsy), 1);
      chk("mid_alu_a", 32'(aa), 9);
      rst = 1'b1; rv = 4'b1010; ra[15:8] = 8'd3; rb[15:8] = 8'd4;
      step();
      chk("mid_rst_valid", 32'(rvld), 0);
      chk("mid_rst_busy", 32'(bsy), 0);
      chk("mid_rst_alu_a", 32'(aa), 0);
      chk("mid_rst_ready", 32'(rrdy4), 0);
      rst = 1'b0;
      #1 chk("post_rst_lowest", 32'(rrdy4), 32'b0010);
      step(); rv = '0;
      chk("post_rst_novalid", 32'(rvld), 0);
      step();
      chk("post_rst_id", 32'(rid), 1);
      chk("post_rst_data", 32'(rdata), 7);
      step();
      // full contention on both instances
      rst = 1'b1;
      step();
      rst = 1'b0;
      rv = 4'b1111; v3 = 3'b111;
      for (int i = 0; i < 4; i++) begin
         ra[i*8 +: 8] = 8'(i); rb[i*8 +: 8] = 8'd10;
      end
      for (int i = 0; i < 3; i++) begin
         a3[i*8 +: 8] = 8'(i); b3[i*8 +: 8] = 8'd20;
      end
      for (int n = 0; n < 5; n++) begin
         #1 chk("full_ready", 32'(rrdy4), 32'(1) << (n % 4));
         if (n < 4) chk("n3_ready", 32'(rrdy3), 32'(1) << (n % 3));
         step();
         step();
         chk("full_id", 32'(rid), 32'(n % 4));
         chk("full_data", 32'(rdata), 32'(10 + n % 4));
         if (n < 4) begin
            chk("n3_id", 32'(rid3), 32'(n % 3));
            chk("n3_data", 32'(rdata3), 32'(20 + n % 3));
         end
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
